// File: rtl/cpu_types_pkg.sv
// Shared CPU control types.
package cpu_types_pkg;

  // Pipeline controller modes: normal flow, HALT draining, stopped.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Count up on inc, holding at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller with stall and flush performance counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hazard,
  input  logic             branch,
  input  logic             jump,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             id_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t       state_q, state_d;
  logic [DCNT_W-1:0] drain_q, drain_d;
  logic              dstall, istall, hstall, redirect;
  logic              stall_inc, flush_inc;

  // Prioritised stall/redirect conditions: data miss over fetch miss over hazard over redirect.
  assign dstall   = mem_req & ~dhit;
  assign istall   = ~ihit & ~dstall;
  assign hstall   = hazard & ~dstall & ~istall;
  assign redirect = (branch | jump) & ~dstall & ~istall & ~hazard;

  // State, drain counter and sticky halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      drain_q <= '0;
      halt    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (state_d == HALTED) begin
        halt <= 1'b1;
      end
    end
  end

  // Next state, latch enables, bubble inserts and counter increments.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dstall) begin
          stall_inc = 1'b1;
        end else if (istall || hstall) begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (redirect) begin
            // A redirect flushes the HALT in ID, so it also wins over id_halt.
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (id_halt) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end

      DRAIN: begin
        // Only bubbles follow the HALT, so branch/jump/hazard are irrelevant here.
        if (dstall) begin
          stall_inc = 1'b1;
        end else begin
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifid_flush = 1'b1;
          stall_inc  = istall;
          if (drain_q == DCNT_W'(DRAIN_CYCLES - 1)) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q + DCNT_W'(1);
          end
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase

    // Reset freezes the whole pipeline regardless of state.
    if (RST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
    end
  end

  sat_counter #(.width(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.width(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W        = 16;
  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int          CNT_MAX      = 65535;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hazard = 1'b0, branch = 1'b0, jump = 1'b0;
  logic             ihit = 1'b1, dhit = 1'b1, mem_req = 1'b0, id_halt = 1'b0;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .CLK        (clk),
    .RST        (rst),
    .hazard     (hazard),
    .branch     (branch),
    .jump       (jump),
    .ihit       (ihit),
    .dhit       (dhit),
    .mem_req    (mem_req),
    .id_halt    (id_halt),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_en    (idex_en),
    .exmem_en   (exmem_en),
    .memwb_en   (memwb_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .halt       (halt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode flags, remaining advancing cycles before halt, integer counters.
  bit       m_drain = 1'b0, m_halted = 1'b0, m_halt = 1'b0;
  int       m_left = 0, m_stall = 0, m_flush = 0;
  bit       dst, ist, hz, rd;
  bit [6:0] e;

  // Compare DUT against the model each cycle (and right after an async reset), then advance the model.
  always begin
    @(negedge clk or posedge rst);
    #1;
    dst = mem_req && !dhit;
    ist = !ihit && !dst;
    hz  = hazard && !dst && !ist;
    rd  = (branch || jump) && !dst && !ist && !hazard;
    if (rst) begin
      m_drain = 1'b0; m_halted = 1'b0; m_halt = 1'b0;
      m_left = 0; m_stall = 0; m_flush = 0;
      e = 7'b0;
    end else if (m_halted)      e = 7'b0000000;
    else if (m_drain)           e = dst ? 7'b0000000 : 7'b0111110;
    else if (dst)               e = 7'b0000000;
    else if (ist || hz)         e = 7'b0011101;
    else if (rd)                e = 7'b1111110;
    else                        e = 7'b1111100;
    chk("ctl{pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl}",
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, e);
    chk("halt", halt, m_halt);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    if (!rst) begin
      if (!m_halted && (dst || ist || (!m_drain && hz)) && m_stall < CNT_MAX) m_stall++;
      if (!m_halted && !m_drain && rd && m_flush < CNT_MAX) m_flush++;
      if (m_drain && !dst) begin
        m_left--;
        if (m_left == 0) begin
          m_drain = 1'b0; m_halted = 1'b1; m_halt = 1'b1;
        end
      end else if (!m_halted && !m_drain && !dst && !ist && !hz && !rd && id_halt) begin
        m_drain = 1'b1;
        m_left  = DRAIN_CYCLES;
      end
    end
  end

  task automatic idle_now();
    hazard = 0; branch = 0; jump = 0; ihit = 1; dhit = 1; mem_req = 0; id_halt = 0;
  endtask

  // One cycle: drive after the rising edge, return just after the falling edge.
  task automatic cyc(input bit h, input bit b, input bit j, input bit ih,
                     input bit dh, input bit mr, input bit hl);
    @(posedge clk); #1;
    hazard = h; branch = b; jump = j; ihit = ih; dhit = dh; mem_req = mr; id_halt = hl;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_now();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    idle_now();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_halt", halt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Data miss for 4 cycles, then release.
    repeat (4) cyc(0, 0, 0, 1, 0, 1, 0);
    chk("dstall_freeze", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    chk("dstall_release_pc_en", pc_en, 1);
    chk("dstall_stall_cnt", stall_cnt, 4);

    // Hazard beats a simultaneous branch.
    do_reset();
    cyc(1, 1, 0, 1, 1, 0, 0);
    chk("hz_br_pc_en", pc_en, 0);
    chk("hz_br_idex_flush", idex_flush, 1);
    chk("hz_br_ifid_flush", ifid_flush, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("hz_br_flush_cnt", flush_cnt, 0);
    chk("hz_br_stall_cnt", stall_cnt, 1);

    // Jump redirect.
    cyc(0, 0, 1, 1, 1, 0, 0);
    chk("jump_ifid_flush", ifid_flush, 1);
    chk("jump_pc_en", pc_en, 1);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("jump_flush_cnt", flush_cnt, 1);

    // Branch during fetch miss is discarded.
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("br_istall_ifid_flush", ifid_flush, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("br_istall_flush_cnt", flush_cnt, 1);

    // HALT together with a redirect stays in RUN.
    cyc(0, 1, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("halt_redirect_pc_en", pc_en, 1);
    chk("halt_redirect_flush_cnt", flush_cnt, 2);

    // HALT drain with one data-miss cycle inside it.
    do_reset();
    cyc(0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("drain_pc_en", pc_en, 0);
    chk("drain_ifid_flush", ifid_flush, 1);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 1, 0, 0);
    chk("drain_ignore_hz_idex_flush", idex_flush, 0);
    chk("drain_halt_pending", halt, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("drain_last_halt", halt, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("halted_halt", halt, 1);
    chk("halted_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
    chk("halted_stall_cnt", stall_cnt, 1);
    repeat (3) cyc(1, 1, 1, 0, 0, 1, 1);
    chk("halted_sticky", halt, 1);
    chk("halted_frozen_stall", stall_cnt, 1);

    // Async reset out of HALTED, between clock edges.
    idle_now();
    #2 rst = 1'b1;
    #2;
    chk("async_rst_halted_halt", halt, 0);
    chk("async_rst_halted_cnt", stall_cnt, 0);
    rst = 1'b0;
    #1;
    chk("async_rst_halted_run", pc_en, 1);

    // Async reset mid-DRAIN.
    cyc(0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("mid_drain_pc_en", pc_en, 0);
    #2 rst = 1'b1;
    #2;
    chk("mid_drain_rst_halt", halt, 0);
    chk("mid_drain_rst_ctl", {pc_en, ifid_en, ifid_flush}, 0);
    rst = 1'b0;
    #1;
    chk("mid_drain_rst_run_pc_en", pc_en, 1);
    chk("mid_drain_rst_run_ifid_flush", ifid_flush, 0);

    // Stall counter saturation.
    do_reset();
    repeat (CNT_MAX) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("sat_full", stall_cnt, 16'hFFFF);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, number of advancing cycles a HALT needs to move from ID to retirement.
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port hazard  in  1  data hazard from the hazard unit.
REQ-006 SHALL have port branch  in  1  taken branch resolved in ID.
REQ-007 SHALL have port jump  in  1  J, JAL or JR in ID.
REQ-008 SHALL have port ihit  in  1  instruction fetch complete this cycle.
REQ-009 SHALL have port dhit  in  1  data access complete this cycle.
REQ-010 SHALL have port mem_req  in  1  dREN or dWEN of the instruction in MEM.
REQ-011 SHALL have port id_halt  in  1  HALT opcode in ID.
REQ-012 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  PC and latch enables.
REQ-013 SHALL have ports ifid_flush, idex_flush  out  1 each  synchronous bubble insert into the named latch.
REQ-014 SHALL have port halt  out  1  sticky processor-halted flag.
REQ-015 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-016 SHALL define dstall = mem_req & !dhit, istall = !ihit & !dstall, hstall = hazard & !dstall & !istall, redirect = (branch | jump) & !dstall & !istall & !hazard.
REQ-017 SHALL implement FSM states RUN, DRAIN and HALTED, plus a drain counter of width clog2(DRAIN_CYCLES+1).
REQ-018 SHALL, on dstall in RUN or DRAIN, drive every enable 0 and both flushes 0 (full freeze).
REQ-019 SHALL, on istall, drive pc_en=0, ifid_en=0, idex_flush=1 and the other enables 1.
REQ-020 SHALL, on hstall, drive pc_en=0, ifid_en=0, idex_flush=1 and exmem_en=memwb_en=1.
REQ-021 SHALL, on redirect, drive all enables 1 and ifid_flush=1; the PC loads the target.
REQ-022 SHALL, with no condition active, drive all enables 1 and both flushes 0.
REQ-023 SHALL discard branch and jump while istall or hstall is active; the unit re-evaluates them on the next cycle.
REQ-024 SHALL move RUN->DRAIN on id_halt with no dstall, istall or hstall, clearing the drain counter; that cycle advances normally.
REQ-025 SHALL, in DRAIN, drive pc_en=0 and ifid_flush=1; the drain counter increments on each non-dstall cycle.
REQ-026 SHALL move DRAIN->HALTED when the drain counter reaches DRAIN_CYCLES-1 on a non-dstall cycle.
REQ-027 SHALL ignore branch, jump and hazard while in DRAIN, because only bubbles follow the HALT.
REQ-028 SHALL, in HALTED, drive every enable 0 and every flush 0, and keep halt=1 until RST.
REQ-029 SHALL increment stall_cnt each cycle in RUN or DRAIN with dstall, istall or hstall, saturating at all-ones.
REQ-030 SHALL increment flush_cnt each redirect cycle, saturating at all-ones.
REQ-031 SHALL keep both counters frozen in HALTED.
REQ-032 SHALL give a simultaneous id_halt and redirect priority to the redirect; the unit stays in RUN because the HALT is flushed.

Reset
REQ-033 SHALL, while RST=1, force state RUN, drain counter 0, halt 0, stall_cnt 0 and flush_cnt 0.
REQ-034 SHALL, while RST=1, force all enables 0 and all flushes 0.
REQ-035 SHALL, on RST assertion in DRAIN or HALTED, return to RUN immediately, asynchronously, with no residual halt.

Structure
REQ-036 SHALL place the ctrl_state_t enum (RUN, DRAIN, HALTED) in cpu_types_pkg.
REQ-037 SHALL implement both counters as instances of one sub-module, sat_counter, with parameter width, ports CLK, RST, inc and count.
REQ-038 SHALL use registered state only for FSM state, the drain counter, halt and the counters; all enables and flushes are combinational from state and inputs.

Verification
REQ-039 SHALL cover: mem_req=1, dhit=0 for 4 cycles, then dhit=1 -> all enables 0 for 4 cycles, normal on cycle 5, stall_cnt=4.
REQ-040 SHALL cover: hazard=1 and branch=1 together for 1 cycle -> pc_en=0, idex_flush=1, ifid_flush=0, flush_cnt unchanged.
REQ-041 SHALL cover: jump=1 for 1 cycle with ihit=1 -> ifid_flush=1, pc_en=1, flush_cnt=1.
REQ-042 SHALL cover: id_halt=1, then one dstall cycle during DRAIN -> HALTED reached after 4 cycles, halt=1 sticky, all enables 0.
REQ-043 SHALL cover: stall_cnt preloaded by 65535 stall cycles, then 1 more -> stall_cnt remains 0xFFFF.
REQ-044 SHALL cover: RST asserted mid-DRAIN -> halt=0 and state RUN without waiting for a CLK edge; all enables 0 until RST deasserts.
